mbist_mux_repair: RTL and testbench
===================================

Name: mbist_mux_repair

Overview:
Next-generation MBIST/functional memory port mux for one dual-port SRAM (port A read, port B write) in a single clock domain. It replaces the single-entry address repair with a NUM_SPARE-entry repair table. Each failing address reported by the MBIST controller is allocated its own spare word. Both ports remap through the table in BIST and functional mode, and overflow and repair status are reported back to the controller.

Parameters:
BIST_ADDR_WD, 9, address width
BIST_DATA_WD, 32, data width; must be a multiple of 8
BIST_REPAIR_ADDR_START, 9'h1FC, address of spare 0; spare i is START+i
NUM_SPARE, 4, repair table depth (1..16); START+NUM_SPARE-1 must be <= 2^BIST_ADDR_WD-1, checked at elaboration
CNT_WD, $clog2(NUM_SPARE+1), width of the repair count

Ports:
clk  in  1  single clock for the table and for both memory ports (mem_clk_a/b are driven externally from clk)
rst_n  in  1  asynchronous active-low reset
bist_en  in  1  1 = MBIST owns the memory
bist_addr  in  BIST_ADDR_WD  MBIST address, shared by both ports
bist_wdata  in  BIST_DATA_WD  MBIST write data
bist_rd  in  1  MBIST read strobe
bist_wr  in  1  MBIST write strobe
bist_error  in  1  one-cycle pulse: compare failure
bist_error_addr  in  BIST_ADDR_WD  failing address
bist_clear  in  1  synchronous clear of the repair table
func_cen_a  in  1  functional port A chip enable, active low
func_addr_a  in  BIST_ADDR_WD  functional port A address
func_dout_a  out  BIST_DATA_WD  read data = mem_dout_a
func_cen_b  in  1  functional port B chip enable, active low
func_web_b  in  1  functional port B write enable, active low
func_mask_b  in  BIST_DATA_WD/8  functional byte mask
func_addr_b  in  BIST_ADDR_WD  functional port B address
func_din_b  in  BIST_DATA_WD  functional write data
mem_cen_a, mem_addr_a, mem_dout_a(in), mem_cen_b, mem_web_b, mem_mask_b, mem_addr_b, mem_din_b  memory-side counterparts of the functional signals, same widths
bist_correct  out  1  1 = every reported error has a spare
bist_repair_full  out  1  sticky: repair overflow or spare-word failure
bist_repair_cnt  out  CNT_WD  number of valid table entries

Behaviour:
- Mux, combinational:
  - bist_en=1: mem_cen_a=!bist_rd, mem_cen_b=!bist_wr, mem_web_b=!bist_wr, mem_mask_b=all ones, mem_din_b=bist_wdata, raw addresses=bist_addr.
  - bist_en=0: all signals come from the func_* inputs.
  - func_dout_a=mem_dout_a always.
- Table: NUM_SPARE entries, each {valid, fault_addr}. Entries fill in index order.
- Remap, combinational on both ports and in both modes:
  - If the raw address equals the fault_addr of a valid entry i, the output address is START+i; otherwise the raw address passes through.
  - Entries are unique by construction, so the lowest index wins if a match is ever ambiguous.
- Allocation, at the posedge clk, evaluated in this priority order:
  1. bist_clear=1: invalidate all entries, cnt=0, full=0. Any bist_error in the same cycle is ignored.
  2. bist_error=1 and bist_en=1:
     - bist_error_addr >= START and < START+NUM_SPARE (a spare word failed): full<=1, no allocation.
     - Address matches a valid entry: no change; duplicates never consume a spare.
     - Else if cnt<NUM_SPARE: entry[cnt] <= {1, bist_error_addr}, cnt<=cnt+1.
     - Else: full<=1, no allocation.
  3. bist_error while bist_en=0: ignored.
- A new entry takes effect on the cycle after the error pulse; the address for that cycle is not remapped.
- bist_correct = !bist_repair_full, combinational from the flop. bist_repair_cnt is registered.
- Reset, async: all entries invalid, cnt=0, full=0, so bist_correct=1. The mux outputs follow their inputs; there is no output reset.
- Reset asserted mid-test: the table is lost, and the MBIST controller reruns the test.
- The table persists when bist_en falls, so functional mode uses the repairs.

Test Plan:
1. Reset, bist_en=0, func_addr_a=9'h010 -> mem_addr_a=9'h010, cnt=0, bist_correct=1, full=0.
2. bist_en=1, bist_error pulse with addr 9'h010 -> from the next cycle, bist_addr=9'h010 gives mem_addr_a=mem_addr_b=9'h1FC, cnt=1; in the pulse cycle itself the address is not remapped.
3. Error at 9'h010 three times, then at 9'h020 -> cnt=2, 9'h020 maps to 9'h1FD, full=0.
4. Five distinct errors 9'h001..9'h005 -> 9'h001..9'h004 map to 9'h1FC..9'h1FF, cnt=4, full=1, correct=0, 9'h005 passes through; then bist_en=0 with func_addr_b=9'h003 -> mem_addr_b=9'h1FE.
5. Error at 9'h1FD (spare) -> full=1, cnt unchanged. bist_clear and bist_error in the same cycle -> cnt=0, full=0, no entry written.
6. rst_n pulsed low mid-test with cnt=3 -> cnt=0, full=0, remap gone immediately (async); bist_en=1 gives mem_cen_a=!bist_rd and mem_mask_b=4'hF.

Source files
------------

// File: rtl/mbist_mux_repair.sv
// MBIST/functional SRAM port mux with an N-entry address repair table; the mux and remap are combinational.
// New table entries take effect the cycle after the error pulse. There is no flow control: every cycle is accepted.
module mbist_mux_repair #(
    parameter int                      BIST_ADDR_WD           = 9,
    parameter int                      BIST_DATA_WD           = 32,
    parameter logic [BIST_ADDR_WD-1:0] BIST_REPAIR_ADDR_START = 9'h1FC,
    parameter int                      NUM_SPARE              = 4,
    parameter int                      CNT_WD                 = $clog2(NUM_SPARE + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      bist_en,
    input  logic [BIST_ADDR_WD-1:0]   bist_addr,
    input  logic [BIST_DATA_WD-1:0]   bist_wdata,
    input  logic                      bist_rd,
    input  logic                      bist_wr,
    input  logic                      bist_error,
    input  logic [BIST_ADDR_WD-1:0]   bist_error_addr,
    input  logic                      bist_clear,
    input  logic                      func_cen_a,
    input  logic [BIST_ADDR_WD-1:0]   func_addr_a,
    output logic [BIST_DATA_WD-1:0]   func_dout_a,
    input  logic                      func_cen_b,
    input  logic                      func_web_b,
    input  logic [BIST_DATA_WD/8-1:0] func_mask_b,
    input  logic [BIST_ADDR_WD-1:0]   func_addr_b,
    input  logic [BIST_DATA_WD-1:0]   func_din_b,
    output logic                      mem_cen_a,
    output logic [BIST_ADDR_WD-1:0]   mem_addr_a,
    input  logic [BIST_DATA_WD-1:0]   mem_dout_a,
    output logic                      mem_cen_b,
    output logic                      mem_web_b,
    output logic [BIST_DATA_WD/8-1:0] mem_mask_b,
    output logic [BIST_ADDR_WD-1:0]   mem_addr_b,
    output logic [BIST_DATA_WD-1:0]   mem_din_b,
    output logic                      bist_correct,
    output logic                      bist_repair_full,
    output logic [CNT_WD-1:0]         bist_repair_cnt
);
    localparam int MASK_WD = BIST_DATA_WD / 8;
    // Exclusive upper bound of the spare window, one bit wider so it cannot wrap.
    localparam logic [BIST_ADDR_WD:0] SPARE_END =
        {1'b0, BIST_REPAIR_ADDR_START} + (BIST_ADDR_WD + 1)'(NUM_SPARE);

    if (NUM_SPARE < 1 || NUM_SPARE > 16) begin : g_bad_num_spare
        $error("NUM_SPARE must be in 1..16");
    end
    if (int'(BIST_REPAIR_ADDR_START) + NUM_SPARE > 2 ** BIST_ADDR_WD) begin : g_bad_spare_range
        $error("spare window exceeds the address space");
    end
    if (BIST_DATA_WD % 8 != 0) begin : g_bad_data_wd
        $error("BIST_DATA_WD must be a multiple of 8");
    end

    typedef struct packed {
        logic                    vld;
        logic [BIST_ADDR_WD-1:0] addr;
    } entry_t;

    entry_t [NUM_SPARE-1:0] tbl_q, tbl_d;
    logic   [CNT_WD-1:0]    cnt_q, cnt_d;
    logic                   full_q, full_d;

    logic [BIST_ADDR_WD-1:0] raw_addr_a, raw_addr_b;
    logic                    err_is_spare, err_dup;

    // Scan high to low so the lowest matching index is the one that sticks.
    function automatic logic [BIST_ADDR_WD-1:0] remap(input entry_t [NUM_SPARE-1:0] tbl,
                                                      input logic [BIST_ADDR_WD-1:0] addr);
        remap = addr;
        for (int i = NUM_SPARE - 1; i >= 0; i--) begin
            if (tbl[i].vld && tbl[i].addr == addr) begin
                remap = BIST_REPAIR_ADDR_START + BIST_ADDR_WD'(i);
            end
        end
    endfunction

    always_comb begin
        if (bist_en) begin
            mem_cen_a  = !bist_rd;
            mem_cen_b  = !bist_wr;
            mem_web_b  = !bist_wr;
            mem_mask_b = {MASK_WD{1'b1}};
            mem_din_b  = bist_wdata;
            raw_addr_a = bist_addr;
            raw_addr_b = bist_addr;
        end else begin
            mem_cen_a  = func_cen_a;
            mem_cen_b  = func_cen_b;
            mem_web_b  = func_web_b;
            mem_mask_b = func_mask_b;
            mem_din_b  = func_din_b;
            raw_addr_a = func_addr_a;
            raw_addr_b = func_addr_b;
        end
    end

    assign mem_addr_a  = remap(tbl_q, raw_addr_a);
    assign mem_addr_b  = remap(tbl_q, raw_addr_b);
    assign func_dout_a = mem_dout_a;

    always_comb begin
        err_is_spare = (bist_error_addr >= BIST_REPAIR_ADDR_START) &&
                       ({1'b0, bist_error_addr} < SPARE_END);
        err_dup = 1'b0;
        for (int i = 0; i < NUM_SPARE; i++) begin
            if (tbl_q[i].vld && tbl_q[i].addr == bist_error_addr) begin
                err_dup = 1'b1;
            end
        end
    end

    always_comb begin
        tbl_d  = tbl_q;
        cnt_d  = cnt_q;
        full_d = full_q;
        if (bist_clear) begin
            tbl_d  = '0;
            cnt_d  = '0;
            full_d = 1'b0;
        end else if (bist_error && bist_en) begin
            if (err_is_spare) begin
                full_d = 1'b1;
            end else if (!err_dup) begin
                if (cnt_q < CNT_WD'(NUM_SPARE)) begin
                    for (int i = 0; i < NUM_SPARE; i++) begin
                        if (CNT_WD'(i) == cnt_q) begin
                            tbl_d[i].vld  = 1'b1;
                            tbl_d[i].addr = bist_error_addr;
                        end
                    end
                    cnt_d = cnt_q + CNT_WD'(1);
                end else begin
                    full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q  <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            tbl_q  <= tbl_d;
            cnt_q  <= cnt_d;
            full_q <= full_d;
        end
    end

    assign bist_correct     = !full_q;
    assign bist_repair_full = full_q;
    assign bist_repair_cnt  = cnt_q;

endmodule

// File: tb/tb_mbist_mux_repair.sv
// Directed bench for mbist_mux_repair: the driver queues expected values, the negedge monitor compares them.
module tb_mbist_mux_repair;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bist_en, bist_rd, bist_wr, bist_error, bist_clear;
    logic [AW-1:0] bist_addr, bist_error_addr;
    logic [DW-1:0] bist_wdata;
    logic          func_cen_a, func_cen_b, func_web_b;
    logic [AW-1:0] func_addr_a, func_addr_b;
    logic [MW-1:0] func_mask_b;
    logic [DW-1:0] func_din_b, func_dout_a, mem_dout_a;
    logic          mem_cen_a, mem_cen_b, mem_web_b;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [MW-1:0] mem_mask_b;
    logic [DW-1:0] mem_din_b;
    logic          bist_correct, bist_repair_full;
    logic [CW-1:0] bist_repair_cnt;

    mbist_mux_repair dut (
        .clk(clk), .rst_n(rst_n), .bist_en(bist_en), .bist_addr(bist_addr),
        .bist_wdata(bist_wdata), .bist_rd(bist_rd), .bist_wr(bist_wr),
        .bist_error(bist_error), .bist_error_addr(bist_error_addr), .bist_clear(bist_clear),
        .func_cen_a(func_cen_a), .func_addr_a(func_addr_a), .func_dout_a(func_dout_a),
        .func_cen_b(func_cen_b), .func_web_b(func_web_b), .func_mask_b(func_mask_b),
        .func_addr_b(func_addr_b), .func_din_b(func_din_b),
        .mem_cen_a(mem_cen_a), .mem_addr_a(mem_addr_a), .mem_dout_a(mem_dout_a),
        .mem_cen_b(mem_cen_b), .mem_web_b(mem_web_b), .mem_mask_b(mem_mask_b),
        .mem_addr_b(mem_addr_b), .mem_din_b(mem_din_b),
        .bist_correct(bist_correct), .bist_repair_full(bist_repair_full),
        .bist_repair_cnt(bist_repair_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {
        S_ADDR_A, S_ADDR_B, S_CNT, S_FULL, S_CORRECT, S_CEN_A, S_CEN_B,
        S_WEB_B, S_MASK_B, S_DIN_B, S_DOUT_A
    } sel_t;

    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [31:0] actual(input sel_t s);
        case (s)
            S_ADDR_A:  actual = 32'(mem_addr_a);
            S_ADDR_B:  actual = 32'(mem_addr_b);
            S_CNT:     actual = 32'(bist_repair_cnt);
            S_FULL:    actual = 32'(bist_repair_full);
            S_CORRECT: actual = 32'(bist_correct);
            S_CEN_A:   actual = 32'(mem_cen_a);
            S_CEN_B:   actual = 32'(mem_cen_b);
            S_WEB_B:   actual = 32'(mem_web_b);
            S_MASK_B:  actual = 32'(mem_mask_b);
            S_DIN_B:   actual = mem_din_b;
            default:   actual = func_dout_a;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.sel);
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input sel_t sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_err(input logic [AW-1:0] a);
        bist_error      = 1'b1;
        bist_error_addr = a;
        step();
        bist_error = 1'b0;
    endtask

    task automatic do_clear();
        bist_clear = 1'b1;
        step();
        bist_clear = 1'b0;
    endtask

    task automatic chk_bist_addr(input string name, input logic [AW-1:0] a, input logic [AW-1:0] exp);
        bist_addr = a;
        expect_val(name, S_ADDR_A, 32'(exp));
        expect_val(name, S_ADDR_B, 32'(exp));
        step();
    endtask

    task automatic chk_status(input string name, input int cnt, input logic full);
        expect_val({name, "_cnt"}, S_CNT, 32'(cnt));
        expect_val({name, "_full"}, S_FULL, 32'(full));
        expect_val({name, "_correct"}, S_CORRECT, 32'(!full));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst_n = 1'b0;
        bist_en = 1'b0; bist_rd = 1'b0; bist_wr = 1'b0; bist_error = 1'b0; bist_clear = 1'b0;
        bist_addr = '0; bist_error_addr = '0; bist_wdata = 32'hA5A5_0F0F;
        func_cen_a = 1'b1; func_cen_b = 1'b1; func_web_b = 1'b1; func_mask_b = 4'h5;
        func_addr_a = 9'h010; func_addr_b = 9'h011; func_din_b = 32'h1234_5678;
        mem_dout_a = 32'hDEAD_BEEF;

        // Reset state and functional pass-through.
        step();
        chk_status("rst", 0, 1'b0);
        expect_val("rst_addr_a", S_ADDR_A, 32'h010);
        expect_val("func_addr_b", S_ADDR_B, 32'h011);
        expect_val("func_mask_b", S_MASK_B, 32'h5);
        expect_val("func_din_b", S_DIN_B, 32'h1234_5678);
        expect_val("func_cen_a", S_CEN_A, 32'h1);
        expect_val("dout_a", S_DOUT_A, 32'hDEAD_BEEF);
        step();
        rst_n = 1'b1;
        step();

        // First error: not remapped in the pulse cycle, remapped afterwards.
        bist_en = 1'b1; bist_rd = 1'b1; bist_wr = 1'b1; bist_addr = 9'h010;
        bist_error = 1'b1; bist_error_addr = 9'h010;
        expect_val("pulse_cycle_addr_a", S_ADDR_A, 32'h010);
        expect_val("pulse_cycle_cnt", S_CNT, 32'h0);
        step();
        bist_error = 1'b0;
        chk_status("t2", 1, 1'b0);
        expect_val("t2_cen_a", S_CEN_A, 32'h0);
        expect_val("t2_cen_b", S_CEN_B, 32'h0);
        expect_val("t2_web_b", S_WEB_B, 32'h0);
        expect_val("t2_mask_b", S_MASK_B, 32'hF);
        expect_val("t2_din_b", S_DIN_B, 32'hA5A5_0F0F);
        chk_bist_addr("t2_remap_010", 9'h010, 9'h1FC);

        // Duplicates never consume a spare.
        pulse_err(9'h010);
        pulse_err(9'h010);
        pulse_err(9'h010);
        pulse_err(9'h020);
        chk_status("t3", 2, 1'b0);
        chk_bist_addr("t3_remap_020", 9'h020, 9'h1FD);

        // Overflow.
        do_clear();
        chk_status("t4_clr", 0, 1'b0);
        for (int i = 1; i <= 5; i++) pulse_err(AW'(i));
        chk_status("t4", 4, 1'b1);
        chk_bist_addr("t4_remap_001", 9'h001, 9'h1FC);
        chk_bist_addr("t4_remap_002", 9'h002, 9'h1FD);
        chk_bist_addr("t4_remap_004", 9'h004, 9'h1FF);
        chk_bist_addr("t4_pass_005", 9'h005, 9'h005);
        bist_en = 1'b0; func_cen_b = 1'b0; func_addr_b = 9'h003;
        expect_val("t4_func_remap_b", S_ADDR_B, 32'h1FE);
        expect_val("t4_func_cen_b", S_CEN_B, 32'h0);
        expect_val("t4_func_web_b", S_WEB_B, 32'h1);
        step();

        // Spare-word failure, clear/error collision, error while bist_en=0.
        do_clear();
        bist_en = 1'b1;
        pulse_err(9'h1FD);
        chk_status("t5_spare", 0, 1'b1);
        bist_clear = 1'b1;
        pulse_err(9'h030);
        bist_clear = 1'b0;
        chk_status("t5_clr_err", 0, 1'b0);
        chk_bist_addr("t5_no_entry_030", 9'h030, 9'h030);
        bist_en = 1'b0;
        pulse_err(9'h040);
        func_addr_a = 9'h040;
        expect_val("t5_func_err_ignored_addr", S_ADDR_A, 32'h040);
        chk_status("t5_func_err", 0, 1'b0);
        step();

        // Async reset mid-test drops the table.
        bist_en = 1'b1;
        pulse_err(9'h0A0);
        pulse_err(9'h0A1);
        pulse_err(9'h0A2);
        chk_status("t6_pre", 3, 1'b0);
        chk_bist_addr("t6_remap_0A1", 9'h0A1, 9'h1FD);
        bist_rd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_status("t6_rst", 0, 1'b0);
        expect_val("t6_remap_gone", S_ADDR_A, 32'h0A1);
        expect_val("t6_cen_a", S_CEN_A, 32'h1);
        expect_val("t6_mask_b", S_MASK_B, 32'hF);
        step();
        rst_n = 1'b1;
        mem_dout_a = 32'h0BAD_F00D;
        expect_val("t6_dout_a", S_DOUT_A, 32'h0BAD_F00D);
        step();

        repeat (3) step();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
